// File: rtl/tmr_scrub_ctrl.sv
// -----------------------------------------------------------------------------
// tmr_scrub_ctrl
//
// Supervises a bank of TMR majority voters through their tmrErr flags and
// sequences refresh ("scrub") of the triplicated registers behind them.
// A voter error, or expiry of the programmable periodic timer, launches a
// masked scrub request over a req/ack handshake. After the ack the controller
// waits for the voters to settle, re-checks the scrubbed groups, retries a
// bounded number of times and finally escalates to a sticky fault.
//
// Ports
//   clk           in   system clock, rising edge
//   rstn          in   asynchronous active-low reset
//   en_i          in   controller enable
//   err_i         in   [N_VOTERS]     tmrErr flags, sampled synchronously
//   period_i      in   [PERIOD_WIDTH] periodic scrub interval, 0 disables
//   clr_i         in   clears sticky flags, event counter and fault
//   scrub_req_o   out  scrub request, held until ack
//   scrub_mask_o  out  [N_VOTERS]     groups to refresh, stable while req high
//   scrub_ack_i   in   scrub done
//   err_sticky_o  out  [N_VOTERS]     sticky OR of err_i per group
//   err_cnt_o     out  [CNT_WIDTH]    saturating count of error events
//   fault_o       out  persistent error, sticky until clr_i
//   busy_o        out  high while in SCRUB/SETTLE/CHECK
//
// States
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | watching voters, running the periodic timer
//   S_SCRUB  | scrub_req_o high, waiting for scrub_ack_i
//   S_SETTLE | ack received, letting voters settle for SETTLE_CYCLES cycles
//   S_CHECK  | one-cycle re-check of the scrubbed groups
//   S_FAULT  | retries exhausted, fault_o high until clr_i
// -----------------------------------------------------------------------------
module tmr_scrub_ctrl #(
  parameter int N_VOTERS      = 8,
  parameter int CNT_WIDTH     = 16,
  parameter int PERIOD_WIDTH  = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en_i,
  input  logic [N_VOTERS-1:0]     err_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  input  logic                    clr_i,
  output logic                    scrub_req_o,
  output logic [N_VOTERS-1:0]     scrub_mask_o,
  input  logic                    scrub_ack_i,
  output logic [N_VOTERS-1:0]     err_sticky_o,
  output logic [CNT_WIDTH-1:0]    err_cnt_o,
  output logic                    fault_o,
  output logic                    busy_o
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCRUB  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic [N_VOTERS-1:0]     mask_d;
  logic                    cnt_inc;
  logic                    err_any;
  logic                    timer_run;
  logic                    timer_exp;
  logic                    recheck_err;
  logic                    busy_d;

  assign err_any     = |err_i;
  assign timer_run   = en_i && (period_i != '0);
  assign timer_exp   = timer_run && (timer_q == (period_i - PERIOD_WIDTH'(1)));
  assign recheck_err = (err_i & scrub_mask_o) != '0;

  // Next-state logic. The timer defaults to zero so that it is cleared in
  // every state other than IDLE and whenever it is not allowed to run.
  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    retry_d  = retry_q;
    settle_d = settle_q;
    mask_d   = scrub_mask_o;
    cnt_inc  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en_i && err_any) begin
          state_d = S_SCRUB;
          mask_d  = err_i;
          cnt_inc = 1'b1;
          retry_d = '0;
        end else if (timer_exp) begin
          state_d = S_SCRUB;
          mask_d  = '1;
          retry_d = '0;
        end else if (timer_run) begin
          timer_d = timer_q + PERIOD_WIDTH'(1);
        end
      end

      S_SCRUB: begin
        if (scrub_ack_i) begin
          state_d  = S_SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end

      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end

      S_CHECK: begin
        if (!en_i || !recheck_err) begin
          state_d = S_IDLE;
        end else if (retry_q == RETRY_LAST) begin
          // A clear arriving on the escalation cycle dominates: the fault is
          // never raised, so the controller simply returns to IDLE.
          state_d = clr_i ? S_IDLE : S_FAULT;
        end else begin
          state_d = S_SCRUB;
          retry_d = retry_q + RW'(1);
          mask_d  = err_i;
        end
      end

      S_FAULT: begin
        if (clr_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d == S_SCRUB) || (state_d == S_SETTLE) ||
                  (state_d == S_CHECK);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      settle_q     <= '0;
      scrub_mask_o <= '0;
      scrub_req_o  <= 1'b0;
      busy_o       <= 1'b0;
      fault_o      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      settle_q     <= settle_d;
      scrub_mask_o <= mask_d;
      scrub_req_o  <= (state_d == S_SCRUB);
      busy_o       <= busy_d;
      fault_o      <= (state_d == S_FAULT);
    end
  end

  // Status: clear always wins over a same-cycle accumulate or increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_sticky_o <= '0;
      err_cnt_o    <= '0;
    end else begin
      if (clr_i) begin
        err_sticky_o <= '0;
      end else if (en_i) begin
        err_sticky_o <= err_sticky_o | err_i;
      end

      if (clr_i) begin
        err_cnt_o <= '0;
      end else if (cnt_inc && (err_cnt_o != '1)) begin
        err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule
